// File: rtl/trade_report_framer.sv
// Buffers order-book report words in a FIFO and emits them as framed bytes
// (MAGIC, seq, N, N words MSB first) on an 8-bit AXI-Stream.
module trade_report_framer #(
   parameter int         FIFO_DEPTH    = 64,
   parameter int         MAX_WORDS     = 16,
   parameter int         FLUSH_TIMEOUT = 32,
   parameter logic [7:0] MAGIC         = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          trade_valid,
   input  logic [31:0]                   trade_info,
   output logic [7:0]                    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   overflow_cnt,
   output logic [7:0]                    frame_seq
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LVW = AW + 1;
   localparam int IW  = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [LVW-1:0] DEPTH_L   = LVW'(FIFO_DEPTH);
   localparam logic [LVW-1:0] MAXW_L    = LVW'(MAX_WORDS);
   localparam logic [IW-1:0]  TIMEOUT_L = IW'(FLUSH_TIMEOUT);

   typedef enum logic [2:0] {IDLE, HDR_MAGIC, HDR_SEQ, HDR_CNT, PAYLOAD} state_t;
   state_t state, state_nxt;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] idle_cnt;
   logic [31:0]   shreg;
   logic [1:0]    byte_idx;
   logic [7:0]    n_words, word_idx;
   logic          full, wr_en, rd_en, hs, start, word_done, frame_done;

   // Fullness uses the registered level, so a same-cycle pop never frees room for a write.
   assign full       = (fifo_level == DEPTH_L);
   assign wr_en      = trade_valid && !full;
   assign hs         = m_axis_tvalid && m_axis_tready;
   assign word_done  = (state == PAYLOAD) && hs && (byte_idx == 2'd3);
   assign frame_done = word_done && (word_idx == n_words - 8'd1);
   assign rd_en      = ((state == HDR_CNT) && hs) || (word_done && !frame_done);
   assign start      = (state == IDLE) &&
                       ((fifo_level >= MAXW_L) ||
                        ((fifo_level != '0) && (idle_cnt == TIMEOUT_L)));

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= trade_info;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         overflow_cnt <= '0;
         idle_cnt     <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (trade_valid && full && (overflow_cnt != 16'hFFFF))
            overflow_cnt <= overflow_cnt + 1'b1;
         if (trade_valid)
            idle_cnt <= '0;
         else if (idle_cnt != TIMEOUT_L)
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      m_axis_tlast  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = HDR_MAGIC;
         end
         HDR_MAGIC: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = MAGIC;
            if (hs) state_nxt = HDR_SEQ;
         end
         HDR_SEQ: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = frame_seq;
            if (hs) state_nxt = HDR_CNT;
         end
         HDR_CNT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = n_words;
            if (hs) state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = shreg[31:24];
            m_axis_tlast  = (byte_idx == 2'd3) && (word_idx == n_words - 8'd1);
            if (frame_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next word is popped on the handshake that finishes the previous one, so it is ready at byte 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         byte_idx  <= '0;
         n_words   <= '0;
         word_idx  <= '0;
         frame_seq <= '0;
      end else begin
         if (start) begin
            n_words  <= 8'((fifo_level >= MAXW_L) ? MAXW_L : fifo_level);
            word_idx <= '0;
            byte_idx <= '0;
         end
         if ((state == HDR_CNT) && hs) shreg <= mem[rd_ptr];
         if ((state == PAYLOAD) && hs) begin
            if (byte_idx == 2'd3) begin
               byte_idx <= '0;
               word_idx <= word_idx + 1'b1;
               if (!frame_done) shreg <= mem[rd_ptr];
            end else begin
               byte_idx <= byte_idx + 1'b1;
               shreg    <= {shreg[23:0], 8'h00};
            end
         end
         if (frame_done) frame_seq <= frame_seq + 1'b1;
      end
   end

endmodule
